// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_pkg                                                       |
// | Function codes, FSM states and decode helpers for muldiv_seq.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package muldiv_pkg;

  typedef enum logic [3:0] {
    F_MFHI  = 4'b0000,
    F_MTHI  = 4'b0001,
    F_MFLO  = 4'b0010,
    F_MTLO  = 4'b0011,
    F_MULT  = 4'b1000,
    F_MULTU = 4'b1001,
    F_DIV   = 4'b1010,
    F_DIVU  = 4'b1011
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // True for the four iterative codes (10xx).
  function automatic logic is_muldiv(input func_e f);
    return (f[3:2] == 2'b10);
  endfunction

  // True for DIV/DIVU; only meaningful when is_muldiv() holds.
  function automatic logic is_div(input func_e f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  // True for the signed variants MULT/DIV.
  function automatic logic is_signed_op(input func_e f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_seq                                                       |
// | Iterative N-bit HI/LO multiply/divide unit: one shift-add or     |
// | restoring-subtract step per cycle on operand magnitudes, sign    |
// | fix-up on the final edge, start/busy/done handshake, dz flag.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   f,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  localparam int             CW     = $clog2(N + 1);
  localparam logic [CW-1:0]  c_last = CW'(N - 1);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  func_e           r_func;
  logic            r_qneg;   // product / quotient must be negated
  logic            r_rneg;   // remainder must be negated (dividend sign)
  logic [N-1:0]    r_opb;    // |b|: multiplicand or divisor
  logic [2*N-1:0]  r_acc;    // product accumulator; low half is dividend/quotient
  logic [N:0]      r_rem;    // partial remainder

  func_e           w_f;
  logic            w_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [N-1:0]    w_a_mag;
  logic [N-1:0]    w_b_mag;
  logic [N:0]      w_sum;
  logic [2*N-1:0]  w_mul_next;
  logic [N:0]      w_rem_sh;
  logic [N:0]      w_rem_sub;
  logic            w_ge;
  logic [2*N-1:0]  w_prod_fix;
  logic [N-1:0]    w_quo_fix;
  logic [N-1:0]    w_rmd_fix;
  logic            w_b_zero;

  assign w_f     = func_e'(f);
  assign w_sgn   = is_signed_op(w_f);
  assign w_a_neg = w_sgn & a[N-1];
  assign w_b_neg = w_sgn & b[N-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator (with carry) right by one.
  assign w_sum      = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[N-1:1]} : {1'b0, r_acc[2*N-1:1]};

  // Restoring divide: bring the next dividend bit into the remainder and try a subtract.
  assign w_rem_sh  = {r_rem[N-1:0], r_acc[N-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_opb};
  assign w_ge      = (w_rem_sh >= {1'b0, r_opb});

  assign w_prod_fix = r_qneg ? -r_acc : r_acc;
  assign w_quo_fix  = r_qneg ? -r_acc[N-1:0] : r_acc[N-1:0];
  assign w_rmd_fix  = N'(r_rneg ? -r_rem : r_rem);
  assign w_b_zero   = (r_opb == '0);

  assign busy = (r_state != IDLE);

  // View port follows the live function code, not the latched one.
  always_comb begin
    y = '0;
    case (f)
      4'b0000: y = hi;
      4'b0010: y = lo;
      default: y = '0;
    endcase
  end

  // Control FSM plus datapath: accept, iterate N steps, fix up and write back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_func  <= F_MFHI;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (w_f == F_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (w_f == F_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end else if (is_muldiv(w_f)) begin
              r_func  <= w_f;
              r_cnt   <= '0;
              r_qneg  <= w_a_neg ^ w_b_neg;
              r_rneg  <= w_a_neg;
              r_opb   <= w_b_mag;
              r_acc   <= {{N{1'b0}}, w_a_mag};
              r_rem   <= '0;
              r_state <= RUN;
            end else begin
              // MFHI/MFLO and unassigned codes complete without touching HI/LO.
              done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (is_div(r_func)) begin
            r_rem <= w_ge ? w_rem_sub : w_rem_sh;
            r_acc <= {r_acc[2*N-1:N], r_acc[N-2:0], w_ge};
          end else begin
            r_acc <= w_mul_next;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= FIN;
          end
        end

        FIN: begin
          r_state <= IDLE;
          done    <= 1'b1;
          if (is_div(r_func)) begin
            if (w_b_zero) begin
              dz <= 1'b1;
            end else begin
              hi <= w_rmd_fix;
              lo <= w_quo_fix;
              dz <= 1'b0;
            end
          end else begin
            {hi, lo} <= w_prod_fix;
            dz       <= 1'b0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
